o_serdes_tx: RTL

Single-clock parallel-to-serial transmitter that drives the data input of the differential output buffer. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per CLK cycle on Q. It sends words back-to-back with no gap bits, and drives a defined idle level when no data is available. A registered output-enable travels alongside the data for tri-state or enable control downstream.

---
 rtl/o_serdes_tx.sv | 121 ++++++++++++
 1 files changed

// File: rtl/o_serdes_tx.sv
// Parallel-to-serial transmitter: WIDTH-bit words in over valid/ready, one bit per CLK out on Q.
// Optional link-training pattern generator is enabled by defining O_SERDES_TX_TRAIN_EN.
module o_serdes_tx #(
    parameter int          WIDTH      = 8,
    parameter logic        IDLE_VALUE = 1'b0,
    parameter string       MSB_FIRST  = "FALSE"
`ifdef O_SERDES_TX_TRAIN_EN
    ,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'({5{2'b10}})
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    output logic             D_READY,
    input  logic             OE_IN,
`ifdef O_SERDES_TX_TRAIN_EN
    input  logic             TRAIN,
`endif
    output logic             Q,
    output logic             OE_OUT,
    output logic             BUSY,
    output logic             UNDERRUN
);

    localparam int             CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
    localparam bit             MSB   = (MSB_FIRST == "TRUE");

    if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
        $error("Error: o_serdes_tx instance <%m> has parameter <WIDTH> set to <%0d>. Valid values are 3..10.", WIDTH);
    end
    if (MSB_FIRST != "TRUE" && MSB_FIRST != "FALSE") begin : g_bad_msb_first
        $error("Error: o_serdes_tx instance <%m> has parameter <MSB_FIRST> set to <%s>. Valid values are TRUE, FALSE.", MSB_FIRST);
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [WIDTH-1:0] sreg, sreg_nxt, load_word, load_ord;
    logic             q_p0, q_nxt;
    logic             und_p0, und_nxt;
    logic             oe_p0;
    logic             train_w, boundary, ready_int, load;

    // Words are stored in transmit order so the counter always indexes bit 0 first.
    function automatic logic [WIDTH-1:0] order_bits(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = MSB ? w[WIDTH-1-i] : w[i];
        end
        return r;
    endfunction

`ifdef O_SERDES_TX_TRAIN_EN
    assign train_w   = TRAIN;
    assign load_word = TRAIN ? TRAIN_PATTERN : D;
`else
    assign train_w   = 1'b0;
    assign load_word = D;
`endif

    assign load_ord  = order_bits(load_word);
    assign cnt_inc   = cnt + 1'b1;
    assign boundary  = (state == IDLE) || (cnt == LAST);
    assign ready_int = boundary && !train_w;
    assign load      = boundary && (train_w || (D_VALID && ready_int));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        q_nxt     = q_p0;
        und_nxt   = 1'b0;
        if (load) begin
            state_nxt = SHIFT;
            cnt_nxt   = '0;
            sreg_nxt  = load_ord;
            q_nxt     = load_ord[0];
        end else if (state == SHIFT) begin
            if (cnt == LAST) begin
                state_nxt = IDLE;
                q_nxt     = IDLE_VALUE;
                und_nxt   = 1'b1;
            end else begin
                cnt_nxt = cnt_inc;
                q_nxt   = sreg[cnt_inc];
            end
        end else begin
            q_nxt = IDLE_VALUE;
        end
    end

    // Stage p0: serial bit, status and output-enable registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            sreg   <= '0;
            q_p0   <= IDLE_VALUE;
            und_p0 <= 1'b0;
            oe_p0  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sreg   <= sreg_nxt;
            q_p0   <= q_nxt;
            und_p0 <= und_nxt;
            oe_p0  <= OE_IN;
        end
    end

    assign D_READY  = ready_int && !RST;
    assign Q        = q_p0;
    assign OE_OUT   = oe_p0;
    assign BUSY     = (state == SHIFT);
    assign UNDERRUN = und_p0;

endmodule
